// File: rtl/delay_commutator.sv
// delay_commutator: delay-switch-delay commutator for an MDC FFT pipeline.
// Pairs samples DEPTH valid positions apart across the two lanes. The upper
// lane is delayed by DEPTH, a phase counter picks pass/cross, and the lower
// result is delayed by DEPTH again. Lanes are {re, im}, each Nbits wide.
// Optional feature: define DELAY_COMMUTATOR_BYPASS_EN to add a 'bypass'
// input that routes the inputs straight to the output registers and freezes
// the commutator state for the duration.
module delay_commutator #(
  parameter int Nbits = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sync,
`ifdef DELAY_COMMUTATOR_BYPASS_EN
  input  logic               bypass,
`endif
  input  logic [2*Nbits-1:0] in_up,
  input  logic [2*Nbits-1:0] in_down,
  output logic               out_valid,
  output logic [2*Nbits-1:0] out_up,
  output logic [2*Nbits-1:0] out_down
);

  localparam int LaneW  = 2 * Nbits;
  localparam int PhaseW = $clog2(2 * DEPTH);
  localparam int FillW  = $clog2(DEPTH + 1);

  logic [PhaseW-1:0] phase;
  logic [PhaseW-1:0] phaseEff;
  logic [PhaseW-1:0] phaseNext;
  logic [FillW-1:0]  fill;
  logic              fillFull;
  logic              crossMode;
  logic              bypassActive;
  logic              advance;
  logic [LaneW-1:0]  aTap;
  logic [LaneW-1:0]  uVal;
  logic [LaneW-1:0]  sVal;
  logic [LaneW-1:0]  upDly [DEPTH];
  logic [LaneW-1:0]  sDly  [DEPTH];

`ifdef DELAY_COMMUTATOR_BYPASS_EN
  assign bypassActive = bypass;
`else
  assign bypassActive = 1'b0;
`endif

  // Only valid, non-bypassed samples move the commutator forward.
  assign advance = in_valid && !bypassActive;

  // Phase selection, swap decision and lane routing for the current sample.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    phaseEff  = phase;
    phaseNext = '0;
    crossMode = 1'b0;
    uVal      = '0;
    sVal      = '0;
    aTap      = upDly[DEPTH-1];
    // A sync sample is forced to phase 0 regardless of the running count.
    if (in_sync) begin
      phaseEff = '0;
    end
    if (phaseEff != PhaseW'(2 * DEPTH - 1)) begin
      phaseNext = phaseEff + PhaseW'(1);
    end
    crossMode = (phaseEff >= PhaseW'(DEPTH));
    if (crossMode) begin
      uVal = in_down;
      sVal = aTap;
    end else begin
      uVal = aTap;
      sVal = in_down;
    end
  end

  assign fillFull = (fill == FillW'(DEPTH));

  // Delay lines: shift once per accepted sample; the oldest entry is at DEPTH-1.
  always_ff @(posedge clk) begin
    // NOTE: delay storage has no reset; stale data is masked by the fill count, so clearing it buys nothing.
    if (advance) begin
      upDly[0] <= in_up;
      sDly[0]  <= sVal;
      for (int i = 1; i < DEPTH; i++) begin
        upDly[i] <= upDly[i-1];
        sDly[i]  <= sDly[i-1];
      end
    end
  end

  // Phase, fill and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) begin
      phase     <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_up    <= '0;
      out_down  <= '0;
    end else if (bypassActive) begin
      out_valid <= in_valid;
      out_up    <= in_up;
      out_down  <= in_down;
    end else begin
      out_valid <= in_valid && fillFull;
      if (in_valid) begin
        phase <= phaseNext;
        if (!fillFull) begin
          fill <= fill + FillW'(1);
        end else begin
          out_up   <= uVal;
          out_down <= sDly[DEPTH-1];
        end
      end
    end
  end

endmodule
